// File: rtl/mem_port_pkg.sv
// Shared definitions for the halfword/word memory-port initiator: FSM states,
// default address width and the big-endian half-select encoding.
package mem_port_pkg;

    localparam int ADDR_W    = 13;
    localparam int WORD_BITS = 32;
    localparam int HALF_BITS = 16;

    // Half select: 0 picks the upper (first, big-endian) half, 1 the lower.
    localparam logic SEL_HI = 1'b0;
    localparam logic SEL_LO = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    function automatic logic is_misaligned(input logic half, input logic half_sel);
        return !half && (half_sel == SEL_LO);
    endfunction

endpackage

// File: rtl/mem_port_align.sv
// Right-justifies and zero-extends halfword read data taken from a big-endian word.
module mem_port_align
    import mem_port_pkg::*;
(
    input  logic                 half,
    input  logic                 byte_sel,
    input  logic [WORD_BITS-1:0] d_out,
    output logic [WORD_BITS-1:0] rdata
);

    always_comb begin
        rdata = d_out;
        if (half) begin
            if (byte_sel == SEL_HI) begin
                rdata = {{HALF_BITS{1'b0}}, d_out[WORD_BITS-1:HALF_BITS]};
            end else begin
                rdata = {{HALF_BITS{1'b0}}, d_out[HALF_BITS-1:0]};
            end
        end
    end

endmodule

// File: rtl/mem_port_initiator.sv
// Single-outstanding request initiator driving a word memory with halfword support,
// valid/ready request and response channels, and saturating transaction counters.
module mem_port_initiator #(
    parameter int ADDR_W = mem_port_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_half,
    input  logic [ADDR_W:0]   req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              W_En,
    output logic [ADDR_W-1:0] Addr,
    output logic              Byte_Sel,
    output logic              Half_W,
    output logic [31:0]       D_In,
    input  logic [31:0]       D_Out,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);
    import mem_port_pkg::*;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              byte_sel_q, byte_sel_d;
    logic              half_q, half_d;
    logic [31:0]       d_in_q, d_in_d;
    logic              is_write_q, is_write_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic [31:0]       aligned_rdata;

    mem_port_align u_align (
        .half     (half_q),
        .byte_sel (byte_sel_q),
        .d_out    (D_Out),
        .rdata    (aligned_rdata)
    );

    always_comb begin
        state_d     = state_q;
        w_en_d      = 1'b0;
        addr_d      = addr_q;
        byte_sel_d  = byte_sel_q;
        half_d      = half_q;
        d_in_d      = d_in_q;
        is_write_d  = is_write_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (is_misaligned(req_half, req_addr[0])) begin
                        state_d     = ST_RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d    = ST_ISSUE;
                        w_en_d     = req_we;
                        is_write_d = req_we;
                        addr_d     = req_addr[ADDR_W:1];
                        byte_sel_d = req_addr[0];
                        half_d     = req_half;
                        d_in_d     = req_half ? {16'h0, req_wdata[15:0]} : req_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                if (is_write_q) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                rsp_rdata_d = aligned_rdata;
                rsp_err_d   = 1'b0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                // rsp_valid is raised one cycle after entering RESP; the handshake
                // only completes once the client has actually seen it.
                if (rsp_valid_q && rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    if (!rsp_err_q) begin
                        if (is_write_q) begin
                            if (wr_count_q != {CNT_W{1'b1}}) wr_count_d = wr_count_q + 1'b1;
                        end else begin
                            if (rd_count_q != {CNT_W{1'b1}}) rd_count_d = rd_count_q + 1'b1;
                        end
                    end
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered so it stays low throughout reset and rises on the first clock.
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            w_en_q      <= 1'b0;
            addr_q      <= '0;
            byte_sel_q  <= 1'b0;
            half_q      <= 1'b0;
            d_in_q      <= '0;
            is_write_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            w_en_q      <= w_en_d;
            addr_q      <= addr_d;
            byte_sel_q  <= byte_sel_d;
            half_q      <= half_d;
            d_in_q      <= d_in_d;
            is_write_q  <= is_write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign W_En      = w_en_q;
    assign Addr      = addr_q;
    assign Byte_Sel  = byte_sel_q;
    assign Half_W    = half_q;
    assign D_In      = d_in_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule

// File: doc/mem_port_initiator.md
MEM_PORT_INITIATOR -- requirements
Module: mem_port_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, the memory word-address width.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the transaction counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the client presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port req_half, input, 1 bit: 1 = 16-bit access, 0 = 32-bit access.
REQ-009 SHALL have port req_addr, input, ADDR_W+1 bits: halfword address; [ADDR_W:1] is the word address, [0] is the half select.
REQ-010 SHALL have port req_wdata, input, 32 bits: write data; bits [15:0] only for halfword writes.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the client accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: read data; halfword reads are zero-extended and right-justified.
REQ-014 SHALL have port rsp_err, output, 1 bit: the request was misaligned and was not performed.
REQ-015 SHALL have the memory-side outputs W_En (1 bit), Addr (ADDR_W bits), Byte_Sel (1 bit), Half_W (1 bit) and D_In (32 bits), and the memory-side input D_Out (32 bits).
REQ-016 SHALL have outputs rd_count and wr_count, CNT_W bits each: completed-transaction counters.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, CAPTURE and RESP, one request outstanding at most.
REQ-018 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-019 SHALL, on an aligned accept, register Addr = req_addr[ADDR_W:1], Byte_Sel = req_addr[0], Half_W = req_half and D_In, and go to ISSUE.
REQ-020 SHALL place req_wdata[15:0] on D_In[15:0] for halfword writes and pass the full word for word writes.
REQ-021 SHALL treat a word access with req_addr[0]=1 as misaligned: no memory cycle, go directly to RESP with rsp_err=1 and rsp_rdata=0.
REQ-022 SHALL drive W_En=1 for exactly the ISSUE cycle of a write and W_En=0 in every other cycle.
REQ-023 SHALL, for a read, go from ISSUE to CAPTURE; in CAPTURE it samples D_Out at the end of the cycle and goes to RESP.
REQ-024 SHALL align read data as follows: half read with Byte_Sel=0 gives {16'h0, D_Out[31:16]}; Byte_Sel=1 gives {16'h0, D_Out[15:0]}; word read gives D_Out unchanged (big-endian).
REQ-025 SHALL, for a write, go from ISSUE to RESP with rsp_rdata=0 and rsp_err=0.
REQ-026 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-027 SHALL meet this latency, with the accept edge as N: rsp_valid rises after edge N+1 (error), N+2 (write) or N+3 (read).
REQ-028 SHALL increment rd_count or wr_count on the RESP handshake of a successful read or write, saturating at all-ones; errors count in neither.
REQ-029 SHALL hold Addr, Byte_Sel, Half_W and D_In at their last values when idle; D_Out is ignored outside CAPTURE.

Reset
REQ-030 SHALL, on rst_n low, immediately clear state to IDLE and all outputs to 0, including W_En, the counters and the response.
REQ-031 SHALL, on reset during ISSUE, drop W_En at once; the addressed memory contents are undefined and no response is produced.
REQ-032 SHALL make req_ready 1 on the first clock after rst_n is deasserted.

Structure
REQ-033 SHALL take the state enumeration, ADDR_W and the alignment constants from shared package mem_port_pkg.
REQ-034 SHALL use one combinational sub-module, mem_port_align, to perform the read-data alignment of REQ-024.

Verification
REQ-035 The bench SHALL check: word write addr=0x0010, wdata=0xDEADBEEF, then word read addr=0x0010 -> rsp_rdata=0xDEADBEEF, rsp_valid rising exactly after N+3.
REQ-036 The bench SHALL check: half write addr=0x0021, wdata=0x0000ABCD, then half read addr=0x0021 -> 0x0000ABCD; word read addr=0x0020 -> low half 0xABCD.
REQ-037 The bench SHALL check: word read addr=0x0003 -> rsp_err=1 after N+1, W_En never asserted, counters unchanged.
REQ-038 The bench SHALL check: rsp_ready held low for 5 cycles -> response stable and req_ready=0 throughout; accepted on the 6th cycle.
REQ-039 The bench SHALL check: rst_n asserted during the ISSUE cycle of a write -> W_En falls immediately, all outputs 0, req_ready=1 on the first clock after release.
REQ-040 The bench SHALL check: with CNT_W=4, 17 writes -> wr_count saturates at 0xF.
